// File: rtl/filter_crossfade_switch.sv
// Purpose : routes one filter-bank lane to the output, crossfading on filter changes
//           with a linear gain ramp (old lane down to 0, new lane up to full scale).
// Latency : one cycle from in_valid to out_valid; out_data holds between strobes.
// Backpressure: none, a sample is accepted on every in_valid strobe.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   selected_filter   requested lane index (level, indices >= NUM_FILTERS ignored)
//   filt_data         NUM_FILTERS signed W-bit lanes, lane k at [k*W +: W]
//   in_valid          new sample on all lanes
//   out_data          gained sample, out_valid its one-cycle strobe
//   active_filter     lane currently routed to the output
//   busy              high while a fade is in progress
//   switch_count      (SWITCH_COUNT_EN only) saturating count of completed lane changes
//
// Optional feature macro: SWITCH_COUNT_EN
module filter_crossfade_switch #(
  parameter int W           = 16,
  parameter int NUM_FILTERS = 5,
  parameter int RAMP_LOG2   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             selected_filter,
  input  logic [NUM_FILTERS*W-1:0] filt_data,
  input  logic                   in_valid,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  output logic [2:0]             active_filter,
  output logic                   busy
`ifdef SWITCH_COUNT_EN
  ,
  output logic [7:0]             switch_count
`endif
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam logic [GW-1:0] G_MAX = {1'b1, {RAMP_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  g_q, g_d;
  logic [2:0]     active_q, active_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic                     sel_ok;
  logic                     pending;
  logic signed [W-1:0]      lane;
  logic signed [W+GW:0]     prod;
  logic [GW-1:0]            g_inc;

`ifdef SWITCH_COUNT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  always_comb begin
    sel_ok  = ({29'd0, selected_filter} < NUM_FILTERS);
    pending = sel_ok && (selected_filter != active_q);

    lane = '0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      if (active_q == 3'(k)) lane = filt_data[k*W +: W];
    end

    // Gain is zero-extended so the product stays signed; the shift is arithmetic.
    prod  = lane * $signed({1'b0, g_q});
    g_inc = g_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    active_d    = active_q;
    out_data_d  = out_data_q;
    out_valid_d = in_valid;
`ifdef SWITCH_COUNT_EN
    cnt_d       = cnt_q;
`endif

    // The sample always uses the gain and lane in effect before this edge.
    if (in_valid) out_data_d = W'(prod >>> RAMP_LOG2);

    case (state_q)
      PLAY: begin
        // Entry does not wait for a strobe; the ramp itself only moves on strobes.
        if (pending) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (in_valid) begin
          if (g_q != '0) begin
            g_d = g_q - 1'b1;
          end else begin
            // Selection is sampled only here; a request withdrawn mid-fade
            // still completes the fade-in on the same lane.
            g_d     = GW'(1);
            state_d = FADE_IN;
            if (pending) begin
              active_d = selected_filter;
`ifdef SWITCH_COUNT_EN
              if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
            end
          end
        end
      end
      FADE_IN: begin
        if (in_valid) begin
          g_d = g_inc;
          // A new request reverses the ramp from where it is, ahead of the PLAY exit.
          if (pending)             state_d = FADE_OUT;
          else if (g_inc == G_MAX) state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase

    busy_d = (state_d != PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PLAY;
      g_q         <= G_MAX;
      active_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SWITCH_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      active_q    <= active_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SWITCH_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign active_filter = active_q;
  assign busy          = busy_q;
`ifdef SWITCH_COUNT_EN
  assign switch_count  = cnt_q;
`endif

endmodule

// File: tb/tb_filter_crossfade_switch.sv
// Purpose : directed self-checking bench for filter_crossfade_switch.
// Latency : outputs sampled 1 time unit after the edge that consumed each strobe.
// Backpressure: none on this interface.
module tb_filter_crossfade_switch;

  localparam int W  = 16;
  localparam int NF = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        selected_filter;
  logic [NF*W-1:0]   filt_data;
  logic              in_valid;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic [2:0]        active_filter;
  logic              busy;
`ifdef SWITCH_COUNT_EN
  logic [7:0]        switch_count;
`endif

  logic signed [W-1:0] lanes [NF];

  for (genvar k = 0; k < NF; k++) begin : g_lanes
    assign filt_data[k*W +: W] = lanes[k];
  end

  always #5 clk = ~clk;

  filter_crossfade_switch #(.W(W), .NUM_FILTERS(NF), .RAMP_LOG2(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .selected_filter (selected_filter),
    .filt_data       (filt_data),
    .in_valid        (in_valid),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .active_filter   (active_filter),
    .busy            (busy)
`ifdef SWITCH_COUNT_EN
    ,
    .switch_count    (switch_count)
`endif
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
  endtask

  // One strobe consumed on the next edge; checks the registered result.
  task automatic strobe(input int exp, input string nm);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, " out_valid"}, int'(out_valid), 1);
    chk(nm, $signed(out_data), exp);
  endtask

  // One edge without a strobe; output must hold.
  task automatic idle(input int hold, input string nm);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, " idle out_valid"}, int'(out_valid), 0);
    chk({nm, " idle hold"}, $signed(out_data), hold);
  endtask

  typedef struct {
    logic [2:0] sel;
    int         l0;
    int         exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{sel: 3'd0, l0: 1000,   exp: 1000};
    vecs[1] = '{sel: 3'd0, l0: 1000,   exp: 1000};
    vecs[2] = '{sel: 3'd6, l0: -250,   exp: -250};
    vecs[3] = '{sel: 3'd7, l0: 32767,  exp: 32767};
    vecs[4] = '{sel: 3'd5, l0: -32768, exp: -32768};
    vecs[5] = '{sel: 3'd0, l0: 0,      exp: 0};

    reset = 1'b1;
    in_valid = 1'b0;
    selected_filter = 3'd0;
    lanes[0] = 16'sd0;
    lanes[1] = 16'sd111;
    lanes[2] = 16'sd222;
    lanes[3] = 16'sd333;
    lanes[4] = 16'sd444;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", $signed(out_data), 0);
    chk("reset active", int'(active_filter), 0);
    chk("reset busy", int'(busy), 0);
`ifdef SWITCH_COUNT_EN
    chk("reset switch_count", int'(switch_count), 0);
`endif
    reset = 1'b0;

    // Table: PLAY passthrough at full gain, invalid indices ignored.
    for (int i = 0; i < 6; i++) begin
      selected_filter = vecs[i].sel;
      lanes[0] = 16'(vecs[i].l0);
      strobe(vecs[i].exp, $sformatf("vec%0d out_data", i));
      chk($sformatf("vec%0d busy", i), int'(busy), 0);
      chk($sformatf("vec%0d active", i), int'(active_filter), 0);
      for (int j = 0; j < 3; j++) idle(vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Switch 0 -> 2: request taken on an idle edge, then 65 + 63 strobes.
    lanes[0] = 16'sd6400;
    lanes[2] = -16'sd6400;
    selected_filter = 3'd2;
    idle(0, "sw02 entry");
    chk("sw02 busy after request", int'(busy), 1);
    for (int g = 64; g >= 0; g--) strobe(100 * g, $sformatf("sw02 out g=%0d", g));
    chk("sw02 active after fade-out", int'(active_filter), 2);
    for (int g = 1; g <= 63; g++) begin
      strobe(-100 * g, $sformatf("sw02 in g=%0d", g));
      chk($sformatf("sw02 busy g=%0d", g), int'(busy), (g == 63) ? 0 : 1);
    end
    strobe(-6400, "sw02 steady");

    // Switch 2 -> 1 with full-scale lanes: g=1 arithmetic-shift boundaries.
    lanes[2] = -16'sd32768;
    lanes[1] = 16'sd32767;
    selected_filter = 3'd1;
    idle(-6400, "sw21 entry");
    for (int g = 64; g >= 0; g--) strobe(-512 * g, $sformatf("sw21 out g=%0d", g));
    chk("sw21 active", int'(active_filter), 1);
    strobe(511, "sw21 in g=1 max lane");

    // Reversal: request for lane 4 on the g=20 fade-in strobe.
    lanes[1] = 16'sd6400;
    lanes[4] = 16'sd3200;
    for (int g = 2; g <= 19; g++) strobe(100 * g, $sformatf("rev in g=%0d", g));
    selected_filter = 3'd4;
    strobe(2000, "rev reversal sample");
    for (int g = 21; g >= 0; g--) begin
      // Selection wobble during fade-out; value at the g==0 sample wins.
      if (g == 10) selected_filter = 3'd3;
      if (g == 1)  selected_filter = 3'd4;
      if (g == 5)  idle(600, "rev frozen");
      strobe(100 * g, $sformatf("rev out g=%0d", g));
      if (g == 1) chk("rev active still old", int'(active_filter), 1);
    end
    chk("rev active new", int'(active_filter), 4);
    chk("rev busy mid", int'(busy), 1);
    for (int g = 1; g <= 63; g++) strobe(50 * g, $sformatf("rev up g=%0d", g));
    chk("rev busy end", int'(busy), 0);
    strobe(3200, "rev steady");

    // Reset in the middle of a fade-out.
    selected_filter = 3'd0;
    idle(3200, "rst entry");
    strobe(3200, "rst g=64");
    strobe(3150, "rst g=63");
    strobe(3100, "rst g=62");
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", $signed(out_data), 0);
    chk("rst active", int'(active_filter), 0);
    chk("rst busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    lanes[0] = 16'sd777;
    strobe(777, "post-reset full gain");
    chk("post-reset busy", int'(busy), 0);

`ifdef SWITCH_COUNT_EN
    chk("count after reset", int'(switch_count), 0);
    for (int s = 0; s < 300; s++) begin
      @(negedge clk);
      selected_filter = (s % 2 == 0) ? 3'd1 : 3'd0;
      in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      repeat (128) @(negedge clk);
      in_valid = 1'b0;
      if (s == 1) chk("count after 2", int'(switch_count), 2);
    end
    #1;
    chk("count saturated", int'(switch_count), 255);
    chk("count active", int'(active_filter), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
